dot_prod_seq: RTL and testbench
===============================

# dot_prod_seq

Command sequencer that sits directly upstream and downstream of the dot-product kernel. It accepts a job (start index, initial accumulator) on a valid/ready command port, parks or launches the kernel through its `r_enable`/`init_*` inputs, and waits for the kernel's sticky `w_enable`. It then returns the 64-bit result, a cycle count and a timeout flag on a valid/ready response port. This gives the kernel a clean transactional interface and bounds a hung run.

## Interface
- `TIMEOUT_CYCLES`, default 16000: maximum number of WAIT cycles before a job is abandoned (must be ≥1).
- `CNT_W`, default 16: width of the cycle counter and of `rsp_cycles` (must hold `TIMEOUT_CYCLES`).

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  sequencer can accept a command.
- `cmd_i`  in  64  start index for the kernel.
- `cmd_acc`  in  64  initial accumulator for the kernel.
- `k_r_enable`  out  1  kernel hold/restart; drives the kernel's `r_enable`.
- `k_init_i`  out  64  drives the kernel's `init_i`.
- `k_init_acc`  out  64  drives the kernel's `init_acc`.
- `k_w_enable`  in  1  kernel done, sticky until the kernel is restarted.
- `k_result`  in  64  kernel result; valid while `k_w_enable` = 1.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_result`  out  64  captured result; 0 on timeout.
- `rsp_cycles`  out  CNT_W  number of WAIT cycles consumed.
- `rsp_timeout`  out  1  job abandoned at the limit.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, LAUNCH, WAIT, RESP. All outputs decode from registers only; there is no combinational input→output path.
- IDLE:
  - `cmd_ready`=1 and `k_r_enable`=1, so the kernel is held parked.
  - On `cmd_valid & cmd_ready`: latch `cmd_i`→`k_init_i` and `cmd_acc`→`k_init_acc`, then go to LAUNCH.
- LAUNCH (exactly 1 cycle):
  - `k_r_enable`=1, so the kernel loads the latched init values and clears `w_enable`.
  - Clear the counter to 0, then go to WAIT.
- WAIT:
  - `k_r_enable`=0, so the kernel runs.
  - Each cycle, `cnt_next = cnt+1`.
  - If `k_w_enable`=1: `rsp_result`←`k_result`, `rsp_cycles`←`cnt_next`, `rsp_timeout`←0, go to RESP.
  - Else if `cnt_next == TIMEOUT_CYCLES`: `rsp_result`←0, `rsp_cycles`←`TIMEOUT_CYCLES`, `rsp_timeout`←1, go to RESP.
  - Else: `cnt`←`cnt_next`.
  - If completion and the limit occur in the same cycle, completion wins (`rsp_timeout`=0).
- RESP:
  - `rsp_valid`=1 and `k_r_enable`=1, so the kernel is re-parked; on timeout this kills the hung run.
  - Response fields are held stable while `rsp_valid & !rsp_ready`.
  - On `rsp_valid & rsp_ready`: go to IDLE.
- `cmd_ready` is 0 outside IDLE. There is no bypass: a new command cannot be accepted in the same cycle that a response retires.
- `k_init_i` and `k_init_acc` change only on command accept.
- Reset (`rst`=1 at a posedge), dominant in every state including mid-WAIT:
  - state←IDLE, `rsp_valid`=0, `cmd_ready`=1, `k_r_enable`=1, `busy`=0.
  - `k_init_i`, `k_init_acc`, `rsp_result`, `rsp_cycles`, `rsp_timeout` and the counter all←0.
  - Any in-flight job is discarded silently, with no response.
- `k_w_enable` is ignored outside WAIT. Its value is undefined before the first kernel restart.

## Timing
- Command accepted at edge E0: LAUNCH occupies the cycle after E0, and WAIT begins at E1.
- Kernel completion seen in WAIT cycle n: `rsp_valid`=1 from the next cycle, with `rsp_cycles`=n.
- Command→response overhead: 2 cycles plus kernel run time.
- Minimum back-to-back period: overhead + WAIT cycles + 1 RESP cycle + 1 IDLE cycle.
- For the shipped kernel (ROMs `a[k]=b[k]=k`, loop bound 1000), one WAIT cycle count is `7·(1000−init_i)+6`.

## Test plan
- Reset, then `cmd_i`=990, `cmd_acc`=5, `rsp_ready`=1 → one response: `rsp_result`=9,890,390, `rsp_cycles`=76, `rsp_timeout`=0. `busy` is high from the accept edge to the RESP handshake.
- `cmd_i`=0, `cmd_acc`=0 → `rsp_result`=332,833,500, `rsp_cycles`=7006.
- `TIMEOUT_CYCLES`=50, `cmd_i`=0 → `rsp_timeout`=1, `rsp_result`=0, `rsp_cycles`=50. `k_r_enable` returns to 1 the cycle after the limit.
- Backpressure: `rsp_ready`=0 for 20 cycles in RESP → `rsp_valid` and all response fields stay stable, `cmd_ready`=0. A `cmd_valid` offered meanwhile is not accepted until IDLE.
- `cmd_i`=1000 → the kernel exits immediately: `rsp_result`=`cmd_acc`, `rsp_cycles`=6.
- Assert `rst` at WAIT cycle 30 of the `cmd_i`=990 job → no response, next cycle is IDLE with all outputs at reset values. A fresh job then completes correctly.

Source files
------------

// File: rtl/dot_prod_seq.sv
`default_nettype none
// ============================================================================
//  Module      : dot_prod_seq
//  Description : Command/response sequencer wrapped around the dot-product
//                kernel. Accepts a job on a valid/ready command port, parks
//                or launches the kernel, waits for its sticky done flag (or
//                a cycle limit), and returns the result on a valid/ready
//                response port.
//  Revision    : 1.0  initial release
// ============================================================================
module dot_prod_seq #(
  parameter int unsigned TIMEOUT_CYCLES = 16000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  // command port
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [63:0]      cmd_i,
  input  logic [63:0]      cmd_acc,
  // kernel control
  output logic             k_r_enable,
  output logic [63:0]      k_init_i,
  output logic [63:0]      k_init_acc,
  input  logic             k_w_enable,
  input  logic [63:0]      k_result,
  // response port
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [63:0]      rsp_result,
  output logic [CNT_W-1:0] rsp_cycles,
  output logic             rsp_timeout,
  output logic             busy
);

  // Limit expressed at counter width; comparison is done on cnt_d so the
  // counter never needs to exceed the limit itself.
  localparam logic [CNT_W-1:0] c_timeout_cnt = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t           state_q;
  logic             cmd_ready_q;
  logic             k_r_enable_q;
  logic             rsp_valid_q;
  logic             busy_q;
  logic [63:0]      k_init_i_q;
  logic [63:0]      k_init_acc_q;
  logic [63:0]      rsp_result_q;
  logic [CNT_W-1:0] rsp_cycles_q;
  logic             rsp_timeout_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Number of WAIT cycles consumed including the current one.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
  end

  // Sequencer FSM; every output is a dedicated register updated alongside
  // the state so nothing reaches a port combinationally from an input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cmd_ready_q   <= 1'b1;
      k_r_enable_q  <= 1'b1;
      rsp_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      k_init_i_q    <= '0;
      k_init_acc_q  <= '0;
      rsp_result_q  <= '0;
      rsp_cycles_q  <= '0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Kernel stays parked (r_enable high) until a job arrives.
          if (cmd_valid && cmd_ready_q) begin
            k_init_i_q   <= cmd_i;
            k_init_acc_q <= cmd_acc;
            cmd_ready_q  <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= S_LAUNCH;
          end
        end

        S_LAUNCH: begin
          // r_enable is still high this cycle so the kernel loads the init
          // values and drops its done flag; release it for WAIT.
          cnt_q        <= '0;
          k_r_enable_q <= 1'b0;
          state_q      <= S_WAIT;
        end

        S_WAIT: begin
          // Completion is checked first so it wins over a coincident limit.
          if (k_w_enable) begin
            rsp_result_q  <= k_result;
            rsp_cycles_q  <= cnt_d;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            k_r_enable_q  <= 1'b1;
            state_q       <= S_RESP;
          end else if (cnt_d == c_timeout_cnt) begin
            rsp_result_q  <= '0;
            rsp_cycles_q  <= c_timeout_cnt;
            rsp_timeout_q <= 1'b1;
            rsp_valid_q   <= 1'b1;
            k_r_enable_q  <= 1'b1;
            state_q       <= S_RESP;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        S_RESP: begin
          // Response fields are untouched here, so they hold under stall.
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end

        default: begin
          state_q      <= S_IDLE;
          cmd_ready_q  <= 1'b1;
          k_r_enable_q <= 1'b1;
          rsp_valid_q  <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign k_r_enable  = k_r_enable_q;
  assign k_init_i    = k_init_i_q;
  assign k_init_acc  = k_init_acc_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_cycles  = rsp_cycles_q;
  assign rsp_timeout = rsp_timeout_q;
  assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_dot_prod_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dot_prod_seq
//  Description : Self-checking bench for dot_prod_seq with a behavioural
//                model of the shipped kernel (a[k]=b[k]=k, bound 1000), plus
//                a second instance with a short limit and a scripted kernel.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dot_prod_seq;

  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT 1: default limit, behavioural kernel ----------------
  logic          cmd_valid, cmd_ready, k_r_enable, k_w_enable;
  logic [63:0]   cmd_i, cmd_acc, k_init_i, k_init_acc, k_result, rsp_result;
  logic          rsp_valid, rsp_ready, rsp_timeout, busy;
  logic [CW-1:0] rsp_cycles;

  dot_prod_seq #(.TIMEOUT_CYCLES(16000), .CNT_W(CW)) u_dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_i(cmd_i), .cmd_acc(cmd_acc),
    .k_r_enable(k_r_enable), .k_init_i(k_init_i), .k_init_acc(k_init_acc),
    .k_w_enable(k_w_enable), .k_result(k_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_cycles(rsp_cycles), .rsp_timeout(rsp_timeout), .busy(busy)
  );

  // ---------------- DUT 2: limit of 50, scripted kernel ----------------
  logic          cmd_valid2, cmd_ready2, k_r_enable2, k_w_enable2;
  logic [63:0]   k_init_i2, k_init_acc2, rsp_result2;
  logic          rsp_valid2, rsp_ready2, rsp_timeout2, busy2;
  logic [CW-1:0] rsp_cycles2;
  logic [63:0]   k_result2 = 64'hDEAD_BEEF_0000_1234;

  dot_prod_seq #(.TIMEOUT_CYCLES(50), .CNT_W(CW)) u_dut2 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_i(64'd0), .cmd_acc(64'd0),
    .k_r_enable(k_r_enable2), .k_init_i(k_init_i2), .k_init_acc(k_init_acc2),
    .k_w_enable(k_w_enable2), .k_result(k_result2),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_result(rsp_result2),
    .rsp_cycles(rsp_cycles2), .rsp_timeout(rsp_timeout2), .busy(busy2)
  );

  // ---------------- kernel models ----------------
  function automatic logic [63:0] sumsq(input logic [63:0] i);
    logic [63:0] s = 64'd0;
    for (int k = int'(i); k < 1000; k++) s += 64'(k) * 64'(k);
    return s;
  endfunction

  logic [63:0] kin_i = 64'd0, kin_acc = 64'd0;
  int krun = 0;
  int klat;
  always @(posedge clk) begin
    if (k_r_enable) begin
      kin_i   <= k_init_i;
      kin_acc <= k_init_acc;
      krun    <= 0;
    end else begin
      krun <= krun + 1;
    end
  end
  assign klat       = 7 * (1000 - int'(kin_i)) + 6;
  assign k_w_enable = (krun >= klat - 1);
  assign k_result   = kin_acc + sumsq(kin_i);

  int krun2 = 0;
  int lat2  = 0;   // 0 = kernel hangs
  always @(posedge clk) begin
    if (k_r_enable2) krun2 <= 0;
    else             krun2 <= krun2 + 1;
  end
  assign k_w_enable2 = (lat2 != 0) && (krun2 >= lat2 - 1);

  // ---------------- checking infrastructure ----------------
  int checks = 0, failures = 0, rsp_seen = 0;

  typedef struct {
    logic [63:0] i;
    logic [63:0] acc;
    logic [63:0] res;
    logic [63:0] cyc;
    logic        tmo;
  } vec_t;

  vec_t sb_q[$];
  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: compare every retiring response against the oldest expectation.
  always @(negedge clk) begin
    #1;
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp: got result %0h expected no response", rsp_result);
      end else begin
        vec_t e;
        e = sb_q.pop_front();
        chk("rsp_result", rsp_result, e.res);
        chk("rsp_cycles", 64'(rsp_cycles), e.cyc);
        chk("rsp_timeout", 64'(rsp_timeout), 64'(e.tmo));
        rsp_seen++;
      end
    end
  end

  task automatic send(input vec_t v, input bit push);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_i     = v.i;
    cmd_acc   = v.acc;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++;
      failures++;
      $display("FAIL cmd_accept: got cmd_ready 0 expected 1 within 200 cycles");
    end else if (push) begin
      sb_q.push_back(v);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    int n = 0;
    while (rsp_seen < target && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_arrived", 64'(rsp_seen >= target), 64'd1);
  endtask

  task automatic run2(input int lat, input logic [63:0] exp_res,
                      input logic [63:0] exp_cyc, input logic exp_tmo);
    int  n    = 0;
    logic prev = 1'b1;
    lat2 = lat;
    @(negedge clk);
    chk("dut2_cmd_ready", 64'(cmd_ready2), 64'd1);
    cmd_valid2 = 1'b1;
    @(negedge clk);
    cmd_valid2 = 1'b0;
    while (!rsp_valid2 && n < 200) begin
      prev = k_r_enable2;
      @(negedge clk);
      n++;
    end
    chk("dut2_rsp_valid", 64'(rsp_valid2), 64'd1);
    chk("dut2_result", rsp_result2, exp_res);
    chk("dut2_cycles", 64'(rsp_cycles2), exp_cyc);
    chk("dut2_timeout", 64'(rsp_timeout2), 64'(exp_tmo));
    chk("dut2_r_en_wait", 64'(prev), 64'd0);
    chk("dut2_r_en_resp", 64'(k_r_enable2), 64'd1);
    @(negedge clk);
    chk("dut2_back_idle", 64'(busy2), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0]   cap_res;
    logic [CW-1:0] cap_cyc;
    logic          cap_tmo;
    bit            stable;
    int            n;
    vec_t          v;

    vecs[0] = '{i: 64'd990,  acc: 64'd5,                 res: 64'd9890390,   cyc: 64'd76,   tmo: 1'b0};
    vecs[1] = '{i: 64'd0,    acc: 64'd0,                 res: 64'd332833500, cyc: 64'd7006, tmo: 1'b0};
    vecs[2] = '{i: 64'd1000, acc: 64'hFFFF_FFFF_FFFF_FFF0, res: 64'hFFFF_FFFF_FFFF_FFF0, cyc: 64'd6, tmo: 1'b0};
    vecs[3] = '{i: 64'd999,  acc: 64'd1,                 res: 64'd998002,    cyc: 64'd13,   tmo: 1'b0};
    vecs[4] = '{i: 64'd500,  acc: 64'd100,               res: 64'd291291850, cyc: 64'd3506, tmo: 1'b0};
    vecs[5] = '{i: 64'd999,  acc: 64'hFFFF_FFFF_FFFF_FFFF, res: 64'd998000,  cyc: 64'd13,   tmo: 1'b0};

    rst = 1'b1;
    cmd_valid = 1'b0; cmd_i = '0; cmd_acc = '0; rsp_ready = 1'b1;
    cmd_valid2 = 1'b0; rsp_ready2 = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_k_r_enable", 64'(k_r_enable), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_k_init_i", k_init_i, 64'd0);
    chk("rst_rsp_cycles", 64'(rsp_cycles), 64'd0);
    rst = 1'b0;

    // Table-driven jobs, one at a time
    for (int k = 0; k < 6; k++) begin
      send(vecs[k], 1'b1);
      chk("busy_in_job", 64'(busy), 64'd1);
      chk("k_init_i", k_init_i, vecs[k].i);
      wait_rsp(k + 1);
      @(negedge clk);
      chk("busy_after_rsp", 64'(busy), 64'd0);
    end

    // Backpressure: hold the response for 20 cycles with a command pending
    rsp_ready = 1'b0;
    v = '{i: 64'd1000, acc: 64'd42, res: 64'd42, cyc: 64'd6, tmo: 1'b0};
    send(v, 1'b1);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
    cap_res = rsp_result; cap_cyc = rsp_cycles; cap_tmo = rsp_timeout;
    cmd_valid = 1'b1; cmd_i = 64'd999; cmd_acc = 64'd1;
    stable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_result !== cap_res || rsp_cycles !== cap_cyc ||
          rsp_timeout !== cap_tmo || cmd_ready || k_init_i !== 64'd1000)
        stable = 1'b0;
    end
    chk("bp_stable", 64'(stable), 64'd1);
    chk("bp_held_result", cap_res, 64'd42);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle_ready", 64'(cmd_ready), 64'd1);
    sb_q.push_back('{i: 64'd999, acc: 64'd1, res: 64'd998002, cyc: 64'd13, tmo: 1'b0});
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("bp_late_accept", k_init_i, 64'd999);
    wait_rsp(rsp_seen + 1);
    wait_rsp(8);

    // Reset in the middle of WAIT discards the job silently
    send(vecs[0], 1'b0);
    repeat (29) @(negedge clk);
    chk("mid_wait_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("mid_rst_k_r_enable", 64'(k_r_enable), 64'd1);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_k_init_i", k_init_i, 64'd0);
    chk("mid_rst_k_init_acc", k_init_acc, 64'd0);
    chk("mid_rst_rsp_result", rsp_result, 64'd0);
    n = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (rsp_valid) n++;
    end
    chk("mid_rst_no_rsp", 64'(n), 64'd0);
    send(vecs[0], 1'b1);
    wait_rsp(9);

    // Short-limit instance: hang, coincident limit, just-before, early done
    run2(0,  64'd0,                 64'd50, 1'b1);
    run2(50, 64'hDEAD_BEEF_0000_1234, 64'd50, 1'b0);
    run2(49, 64'hDEAD_BEEF_0000_1234, 64'd49, 1'b0);
    run2(1,  64'hDEAD_BEEF_0000_1234, 64'd1,  1'b0);

    repeat (5) @(negedge clk);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
